// File: rtl/m_load_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : m_load_unit_pkg
// Description : Shared definitions for the M-stage load unit.
//               - Load opcode encodings.
//               - Control FSM state encodings.
//               - Inclusive address-window helper.
// Revision    : 1.0 - initial release
// ============================================================================
package m_load_unit_pkg;

    // Load opcode encodings carried on the op port
    localparam logic [2:0] de_None = 3'd0;
    localparam logic [2:0] de_Lw   = 3'd1;
    localparam logic [2:0] de_Lh   = 3'd2;
    localparam logic [2:0] de_Lb   = 3'd3;
    localparam logic [2:0] de_Lhu  = 3'd4;
    localparam logic [2:0] de_Lbu  = 3'd5;
    localparam logic [2:0] de_Ld   = 3'd6;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Inclusive window test. Subtracting the base first lets an address
    // below the base wrap to a huge value, so a single unsigned compare
    // covers both bounds (and avoids an always-true compare when lo is 0).
    function automatic logic in_window(input logic [31:0] a,
                                       input logic [31:0] lo,
                                       input logic [31:0] hi);
        return (a - lo) <= (hi - lo);
    endfunction

endpackage
`default_nettype wire

// File: rtl/m_load_ext.sv
`default_nettype none
// ============================================================================
// Module      : m_load_ext
// Description : Combinational lane select and sign/zero extension.
// Ports       : op     in  3       load type (package encodings)
//               offset in  OFF_W   byte offset of the access in the word
//               word   in  DATA_W  raw bus word
//               ext    out DATA_W  extended result
// Revision    : 1.0 - initial release
// ============================================================================
module m_load_ext
    import m_load_unit_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int OFF_W  = $clog2(DATA_W / 8)
) (
    input  logic [2:0]        op,
    input  logic [OFF_W-1:0]  offset,
    input  logic [DATA_W-1:0] word,
    output logic [DATA_W-1:0] ext
);

    logic [DATA_W-1:0] shifted;

    // Accesses are naturally aligned, so shifting the addressed byte down to
    // bit 0 puts every lane width in the low bits of the shifted word.
    always_comb begin
        shifted = word >> {offset, 3'b000};
        ext     = '0;
        case (op)
            de_Lw:   ext = DATA_W'($signed(shifted[31:0]));
            de_Lh:   ext = DATA_W'($signed(shifted[15:0]));
            de_Lb:   ext = DATA_W'($signed(shifted[7:0]));
            de_Lhu:  ext = DATA_W'(shifted[15:0]);
            de_Lbu:  ext = DATA_W'(shifted[7:0]);
            de_Ld:   ext = shifted;
            default: ext = '0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/m_load_unit.sv
`default_nettype none
// ============================================================================
// Module      : m_load_unit
// Description : Multi-cycle M-stage load unit. Checks address legality,
//               issues one bus read over a req/ack handshake with timeout,
//               extends the addressed lane and reports on a done pulse.
// Ports       : clk, reset (sync, active-low)
//               start/op/addr/flush        command interface
//               busy                       unit not idle
//               bus_req/bus_addr           read request (word aligned)
//               bus_ack/bus_rdata          read response
//               done/rdata/exc_adel/exc_bus result, valid when done=1
// Revision    : 1.0 - initial release
// ============================================================================
module m_load_unit
    import m_load_unit_pkg::*;
#(
    parameter int          DATA_W  = 32,
    parameter logic [31:0] DM_LO   = 32'h0000_0000,
    parameter logic [31:0] DM_HI   = 32'h0000_2FFF,
    parameter logic [31:0] TC_LO   = 32'h0000_7F00,
    parameter logic [31:0] TC_HI   = 32'h0000_7F1B,
    parameter logic [31:0] INT_LO  = 32'h0000_7F20,
    parameter logic [31:0] INT_HI  = 32'h0000_7F23,
    parameter int          TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [2:0]        op,
    input  logic [31:0]       addr,
    input  logic              flush,
    output logic              busy,
    output logic              bus_req,
    output logic [31:0]       bus_addr,
    input  logic              bus_ack,
    input  logic [DATA_W-1:0] bus_rdata,
    output logic              done,
    output logic [DATA_W-1:0] rdata,
    output logic              exc_adel,
    output logic              exc_bus
);

    localparam int OFF_W = $clog2(DATA_W / 8);
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    state_t            state_q,    state_d;
    logic [2:0]        op_q,       op_d;
    logic [OFF_W-1:0]  offset_q,   offset_d;
    logic [31:0]       bus_addr_q, bus_addr_d;
    logic [DATA_W-1:0] rdata_q,    rdata_d;
    logic              exc_adel_q, exc_adel_d;
    logic              exc_bus_q,  exc_bus_d;
    logic [CNT_W-1:0]  cnt_q,      cnt_d;

    logic              addr_fault;
    logic              misalign;
    logic              legal_op;
    logic              in_dm;
    logic              in_tc;
    logic              in_int;
    logic [CNT_W-1:0]  cnt_inc;
    logic              timed_out;
    logic [DATA_W-1:0] ext_data;

    // ------------------------------------------------------------------
    // Address legality, evaluated directly from the command inputs so a
    // faulting load skips the bus entirely.
    // ------------------------------------------------------------------
    always_comb begin
        misalign = 1'b0;
        legal_op = 1'b1;
        case (op)
            de_Lw:          misalign = (addr[1:0] != 2'b00);
            de_Lh, de_Lhu:  misalign = addr[0];
            de_Lb, de_Lbu:  misalign = 1'b0;
            de_Ld: begin
                legal_op = (DATA_W == 64);
                misalign = (addr[2:0] != 3'b000);
            end
            default:        legal_op = 1'b0;
        endcase

        in_dm  = in_window(addr, DM_LO, DM_HI);
        in_tc  = in_window(addr, TC_LO, TC_HI);
        in_int = in_window(addr, INT_LO, INT_HI);

        // Timer registers only support full-word reads
        addr_fault = !legal_op || misalign || !(in_dm || in_tc || in_int)
                   || (in_tc && (op != de_Lw));
    end

    m_load_ext #(
        .DATA_W (DATA_W),
        .OFF_W  (OFF_W)
    ) u_ext (
        .op     (op_q),
        .offset (offset_q),
        .word   (bus_rdata),
        .ext    (ext_data)
    );

    assign cnt_inc   = cnt_q + CNT_W'(1);
    assign timed_out = (cnt_inc == CNT_W'(TIMEOUT));

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        offset_d   = offset_q;
        bus_addr_d = bus_addr_q;
        rdata_d    = rdata_q;
        exc_adel_d = exc_adel_q;
        exc_bus_d  = exc_bus_q;
        cnt_d      = cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (start && (op != de_None) && !flush) begin
                    op_d       = op;
                    offset_d   = addr[OFF_W-1:0];
                    bus_addr_d = {addr[31:OFF_W], {OFF_W{1'b0}}};
                    rdata_d    = '0;
                    exc_adel_d = addr_fault;
                    exc_bus_d  = 1'b0;
                    cnt_d      = '0;
                    state_d    = addr_fault ? ST_DONE : ST_REQ;
                end
            end

            ST_REQ: begin
                cnt_d = cnt_inc;
                if (bus_ack) begin
                    if (flush) begin
                        state_d = ST_IDLE;
                    end else begin
                        rdata_d = ext_data;
                        state_d = ST_DONE;
                    end
                end else if (timed_out) begin
                    if (flush) begin
                        state_d = ST_IDLE;
                    end else begin
                        exc_bus_d = 1'b1;
                        state_d   = ST_DONE;
                    end
                end else if (flush) begin
                    // The request stays up until the slave answers
                    state_d = ST_DRAIN;
                end
            end

            ST_DRAIN: begin
                cnt_d = cnt_inc;
                if (bus_ack || timed_out) begin
                    state_d = ST_IDLE;
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            op_q       <= de_None;
            offset_q   <= '0;
            bus_addr_q <= '0;
            rdata_q    <= '0;
            exc_adel_q <= 1'b0;
            exc_bus_q  <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            offset_q   <= offset_d;
            bus_addr_q <= bus_addr_d;
            rdata_q    <= rdata_d;
            exc_adel_q <= exc_adel_d;
            exc_bus_q  <= exc_bus_d;
            cnt_q      <= cnt_d;
        end
    end

    assign busy     = (state_q != ST_IDLE);
    assign bus_req  = (state_q == ST_REQ) || (state_q == ST_DRAIN);
    assign bus_addr = bus_addr_q;
    // A flush during the result cycle swallows the pulse
    assign done     = (state_q == ST_DONE) && !flush;
    assign rdata    = rdata_q;
    assign exc_adel = exc_adel_q;
    assign exc_bus  = exc_bus_q;

endmodule
`default_nettype wire

// File: tb/tb_m_load_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_m_load_unit
// Description : Directed self-checking bench for m_load_unit. A 32-bit and
//               a 64-bit instance receive the same command stream.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_m_load_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [31:0] addr = 32'd0;
    logic        flush = 1'b0;
    logic        bus_ack = 1'b0;
    logic [63:0] rd_word = 64'd0;

    logic        busy_32, bus_req_32, done_32, exc_adel_32, exc_bus_32;
    logic [31:0] bus_addr_32, rdata_32;
    logic        busy_64, bus_req_64, done_64, exc_adel_64, exc_bus_64;
    logic [31:0] bus_addr_64;
    logic [63:0] rdata_64;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    m_load_unit #(.DATA_W(32)) u_dut32 (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .op        (op),
        .addr      (addr),
        .flush     (flush),
        .busy      (busy_32),
        .bus_req   (bus_req_32),
        .bus_addr  (bus_addr_32),
        .bus_ack   (bus_ack),
        .bus_rdata (rd_word[31:0]),
        .done      (done_32),
        .rdata     (rdata_32),
        .exc_adel  (exc_adel_32),
        .exc_bus   (exc_bus_32)
    );

    m_load_unit #(.DATA_W(64)) u_dut64 (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .op        (op),
        .addr      (addr),
        .flush     (flush),
        .busy      (busy_64),
        .bus_req   (bus_req_64),
        .bus_addr  (bus_addr_64),
        .bus_ack   (bus_ack),
        .bus_rdata (rd_word),
        .done      (done_64),
        .rdata     (rdata_64),
        .exc_adel  (exc_adel_64),
        .exc_bus   (exc_bus_64)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present a command for one edge; returns just after the accept edge
    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [63:0] rd);
        op      = o;
        addr    = a;
        rd_word = rd;
        start   = 1'b1;
        step();
        start   = 1'b0;
    endtask

    task automatic ack_cycle();
        bus_ack = 1'b1;
        step();
        bus_ack = 1'b0;
    endtask

    initial begin
        int n;

        // ---------------- reset ----------------
        step();
        step();
        chk("rst_busy",     busy_32,     0);
        chk("rst_bus_req",  bus_req_32,  0);
        chk("rst_done",     done_32,     0);
        chk("rst_rdata",    rdata_32,    0);
        chk("rst_bus_addr", bus_addr_32, 0);
        chk("rst_adel",     exc_adel_32, 0);
        chk("rst_exc_bus",  exc_bus_32,  0);
        reset = 1'b1;
        step();

        // start with op=NONE is ignored
        issue(3'd0, 32'h10, 64'd0);
        chk("none_busy", busy_32, 0);

        // ---------------- LW, ack on first REQ cycle ----------------
        issue(3'd1, 32'h0000_0010, 64'h0000_0000_8000_1234);
        chk("lw_req",      bus_req_32,  1);
        chk("lw_busy",     busy_32,     1);
        chk("lw_bus_addr", bus_addr_32, 32'h10);
        chk("lw_done_early", done_32,   0);
        ack_cycle();
        chk("lw_done",     done_32,     1);
        chk("lw_rdata",    rdata_32,    32'h8000_1234);
        chk("lw_adel",     exc_adel_32, 0);
        chk("lw_exc_bus",  exc_bus_32,  0);
        chk("lw_req_drop", bus_req_32,  0);
        chk("lw64_rdata",  rdata_64,    64'hFFFF_FFFF_8000_1234);
        step();
        chk("lw_done_once", done_32, 0);
        chk("lw_idle",      busy_32, 0);

        // ---------------- byte / halfword lanes ----------------
        issue(3'd3, 32'h0000_0013, 64'h0000_0000_F122_3344);
        ack_cycle();
        chk("lb_rdata",   rdata_32, 32'hFFFF_FFF1);
        chk("lb64_rdata", rdata_64, 64'hFFFF_FFFF_FFFF_FFF1);
        step();
        issue(3'd5, 32'h0000_0013, 64'h0000_0000_F122_3344);
        ack_cycle();
        chk("lbu_rdata", rdata_32, 32'h0000_00F1);
        step();
        issue(3'd4, 32'h0000_0012, 64'h0000_0000_F122_3344);
        ack_cycle();
        chk("lhu_rdata", rdata_32, 32'h0000_F122);
        step();
        issue(3'd2, 32'h0000_0012, 64'h0000_0000_F122_3344);
        ack_cycle();
        chk("lh_rdata", rdata_32, 32'hFFFF_F122);
        step();

        // Legal edges of the map: last DM byte, full-word timer read
        issue(3'd5, 32'h0000_2FFF, 64'h0000_0000_AB00_0000);
        chk("dmhi_req", bus_req_32, 1);
        ack_cycle();
        chk("dmhi_rdata", rdata_32, 32'h0000_00AB);
        chk("dmhi_adel",  exc_adel_32, 0);
        step();
        issue(3'd1, 32'h0000_7F04, 64'h0000_0000_0000_0042);
        chk("tclw_req", bus_req_32, 1);
        ack_cycle();
        chk("tclw_rdata", rdata_32, 32'h42);
        step();

        // ---------------- address faults ----------------
        issue(3'd2, 32'h0000_0001, 64'd0);
        chk("mis_done",  done_32,     1);
        chk("mis_adel",  exc_adel_32, 1);
        chk("mis_req",   bus_req_32,  0);
        chk("mis_rdata", rdata_32,    0);
        chk("mis_bus",   exc_bus_32,  0);
        step();
        chk("mis_idle", busy_32, 0);
        issue(3'd2, 32'h0000_7F04, 64'd0);
        chk("tch_adel", exc_adel_32, 1);
        chk("tch_req",  bus_req_32,  0);
        step();
        issue(3'd1, 32'h0000_3000, 64'd0);
        chk("oor_adel", exc_adel_32, 1);
        chk("oor_done", done_32,     1);
        step();
        issue(3'd7, 32'h0000_0000, 64'd0);
        chk("op7_adel", exc_adel_32, 1);
        step();

        // ---------------- bus timeout ----------------
        issue(3'd1, 32'h0000_0020, 64'd0);
        n = 0;
        while (bus_req_32 && n < 40) begin
            n++;
            step();
        end
        chk("to_req_cycles", n,           16);
        chk("to_done",       done_32,     1);
        chk("to_exc_bus",    exc_bus_32,  1);
        chk("to_adel",       exc_adel_32, 0);
        chk("to_rdata",      rdata_32,    0);
        step();

        // ---------------- flush during REQ ----------------
        issue(3'd1, 32'h0000_0030, 64'h0000_0000_1111_2222);
        step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("fl_req_held", bus_req_32, 1);
        chk("fl_busy",     busy_32,    1);
        step();
        chk("fl_req_held2", bus_req_32, 1);
        step();
        chk("fl_no_done", done_32, 0);
        ack_cycle();
        chk("fl_idle",     busy_32,    0);
        chk("fl_req_drop", bus_req_32, 0);
        chk("fl_done",     done_32,    0);

        // flush in DONE swallows the pulse
        issue(3'd2, 32'h0000_0001, 64'd0);
        flush = 1'b1;
        #1;
        chk("fld_done", done_32, 0);
        step();
        flush = 1'b0;
        chk("fld_idle", busy_32, 0);

        // ---------------- reset mid-REQ ----------------
        issue(3'd1, 32'h0000_0040, 64'h0000_0000_DEAD_BEEF);
        step();
        reset   = 1'b0;
        bus_ack = 1'b1;
        step();
        chk("rr_busy",     busy_32,     0);
        chk("rr_req",      bus_req_32,  0);
        chk("rr_done",     done_32,     0);
        chk("rr_bus_addr", bus_addr_32, 0);
        chk("rr_rdata",    rdata_32,    0);
        reset   = 1'b1;
        step();
        bus_ack = 1'b0;
        chk("rr_ack_ignored", done_32, 0);
        step();

        // ---------------- 64-bit data path ----------------
        issue(3'd6, 32'h0000_0008, 64'h1122_3344_5566_7788);
        chk("ld32_adel",     exc_adel_32, 1);
        chk("ld64_req",      bus_req_64,  1);
        chk("ld64_bus_addr", bus_addr_64, 32'h8);
        ack_cycle();
        chk("ld64_done",  done_64,     1);
        chk("ld64_rdata", rdata_64,    64'h1122_3344_5566_7788);
        chk("ld64_adel",  exc_adel_64, 0);
        step();
        issue(3'd1, 32'h0000_0004, 64'h9000_0000_0000_0000);
        chk("lwhi_bus_addr", bus_addr_64, 32'h0);
        ack_cycle();
        chk("lwhi64_rdata", rdata_64, 64'hFFFF_FFFF_9000_0000);
        chk("lwhi32_rdata", rdata_32, 32'h0);
        step();
        issue(3'd6, 32'h0000_0004, 64'd0);
        chk("ldmis_adel", exc_adel_64, 1);
        chk("ldmis_req",  bus_req_64,  0);
        step();
        issue(3'd2, 32'h0000_0006, 64'h8001_0000_0000_0000);
        ack_cycle();
        chk("lh64_rdata", rdata_64, 64'hFFFF_FFFF_FFFF_8001);
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
